fetch_unit: RTL

Instruction fetch stage directly upstream of the decoder. It holds the program counter and instruction register, fetches 32-bit words from instruction memory over a req/ready handshake, and slices the held instruction into the opcode/funct3/funct7/register fields the decoder consumes. It uses the decoder's `incr`, `ramR` and `ramW` outputs to sequence the PC, and stalls for one or more extra cycles on loads and stores until data memory signals completion.

---
 rtl/riscv_pkg.sv | 14 +
 rtl/pc_reg.sv | 49 ++++
 rtl/fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared types and constants for the fetch stage: FSM state encoding and the
// reset-time instruction word.
package riscv_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2
  } fetch_state_t;

  // addi x0,x0,0 keeps the decoder on a legal opcode after reset
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/pc_reg.sv
// Program counter register with next-PC selection: redirect (word aligned),
// sequential increment, or hold for refetch.
module pc_reg #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              update_i,
  input  logic              pc_load_i,
  input  logic [ADDR_W-1:0] pc_target_i,
  input  logic              incr_i,
  output logic [ADDR_W-1:0] pc_o
);

  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] pc_d;
  logic              unused_target_lsbs_s;

  assign unused_target_lsbs_s = ^pc_target_i[1:0];

  // Next-PC mux; redirect beats increment, neither means refetch
  always_comb begin
    pc_d = pc_q;
    if (update_i) begin
      if (pc_load_i) begin
        pc_d = {pc_target_i[ADDR_W-1:2], 2'b00};
      end else if (incr_i) begin
        pc_d = pc_q + {{(ADDR_W-3){1'b0}}, 3'b100};
      end else begin
        pc_d = pc_q;
      end
    end else begin
      pc_d = pc_q;
    end
  end

  // PC state register
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: FETCH/EXEC/MEM sequencing, instruction register and
// field slicing for the decoder.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  input  logic              incr,
  input  logic              ramR,
  input  logic              ramW,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_target,
  input  logic              mem_done,
  output logic [6:0]        opcode,
  output logic [2:0]        funct3,
  output logic [6:0]        funct7,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [4:0]        rd,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic              mem_stall,
  output logic              commit
);

  fetch_state_t state_q, state_d;
  logic [31:0]  ir_q, ir_d;
  logic         capture_s;
  logic         mem_op_s;

  assign capture_s = imem_req & imem_ready;
  assign mem_op_s  = ramR | ramW;

  // Next state and IR capture
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      FETCH: begin
        if (capture_s) begin
          ir_d    = imem_rdata;
          state_d = EXEC;
        end else begin
          state_d = FETCH;
        end
      end
      EXEC: begin
        if (mem_op_s) begin
          state_d = MEM;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        if (mem_done) begin
          state_d = FETCH;
        end else begin
          state_d = MEM;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM and instruction register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= FETCH;
      ir_q    <= NOP_INSTR;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Status outputs are forced low during reset regardless of current state
  assign imem_req    = ~reset & (state_q == FETCH);
  assign instr_valid = ~reset & ((state_q == EXEC) | (state_q == MEM));
  assign mem_stall   = ~reset & (state_q == MEM);
  assign commit      = ~reset & (((state_q == EXEC) & ~mem_op_s) |
                                 ((state_q == MEM) & mem_done));

  pc_reg #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clock      (clock),
    .reset      (reset),
    .update_i   (commit),
    .pc_load_i  (pc_load),
    .pc_target_i(pc_target),
    .incr_i     (incr),
    .pc_o       (pc)
  );

  assign imem_addr = pc;
  assign instr     = ir_q;
  assign opcode    = ir_q[6:0];
  assign rd        = ir_q[11:7];
  assign funct3    = ir_q[14:12];
  assign rs1       = ir_q[19:15];
  assign rs2       = ir_q[24:20];
  assign funct7    = ir_q[31:25];

endmodule
